// File: rtl/alu_function_sequencer.sv
// Sequences one ALU instruction through relay settle phases (function setup, result drive),
// then loads the destination register and captures the result and condition flags.
//
//   state  | meaning
//   IDLE   | waiting for start; a non-ALU opcode pulses illegal
//   SETUP  | f driven from the latched function code, result bus off, settling
//   DRIVE  | f held, result bus driven, settling
//   LOAD   | one cycle: destination strobe, result and flags captured at its end
//   FINISH | one cycle: done, f cleared, result bus off
module alu_function_sequencer #(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] instr,
    input  logic [7:0] alu_result,
    input  logic       alu_carry,
    output logic [2:0] f,
    output logic       result_en,
    output logic       load_a,
    output logic       load_d,
    output logic [7:0] result_q,
    output logic       flag_z,
    output logic       flag_s,
    output logic       flag_c,
    output logic       busy,
    output logic       done,
    output logic       illegal
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        DRIVE  = 3'd2,
        LOAD   = 3'd3,
        FINISH = 3'd4
    } state_t;

    localparam logic [3:0] CNT_RELOAD = 4'(SETTLE_CYCLES - 1);
    localparam logic [3:0] OP_ALU     = 4'b1000;
    localparam logic [2:0] FN_NULL    = 3'b111;

    state_t     state_q;
    logic [3:0] cnt_q;
    logic [2:0] fff_q;
    logic       dest_q;
    logic [2:0] f_q;
    logic       result_en_q;
    logic       load_a_q;
    logic       load_d_q;
    logic [7:0] res_q;
    logic       z_q;
    logic       s_q;
    logic       c_q;
    logic       busy_q;
    logic       done_q;
    logic       illegal_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            fff_q       <= 3'd0;
            dest_q      <= 1'b0;
            f_q         <= 3'd0;
            result_en_q <= 1'b0;
            load_a_q    <= 1'b0;
            load_d_q    <= 1'b0;
            res_q       <= 8'h00;
            z_q         <= 1'b0;
            s_q         <= 1'b0;
            c_q         <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            load_a_q  <= 1'b0;
            load_d_q  <= 1'b0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (instr[7:4] == OP_ALU) begin
                            fff_q   <= instr[2:0];
                            dest_q  <= instr[3];
                            f_q     <= instr[2:0];
                            busy_q  <= 1'b1;
                            cnt_q   <= CNT_RELOAD;
                            state_q <= SETUP;
                        end else begin
                            illegal_q <= 1'b1;
                        end
                    end
                end
                SETUP: begin
                    if (cnt_q == 4'd0) begin
                        result_en_q <= 1'b1;
                        cnt_q       <= CNT_RELOAD;
                        state_q     <= DRIVE;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                DRIVE: begin
                    if (cnt_q == 4'd0) begin
                        // NULL still walks through LOAD but never strobes a register
                        if (fff_q != FN_NULL) begin
                            load_a_q <= ~dest_q;
                            load_d_q <= dest_q;
                        end
                        state_q <= LOAD;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                LOAD: begin
                    if (fff_q != FN_NULL) begin
                        res_q <= alu_result;
                        z_q   <= (alu_result == 8'h00);
                        s_q   <= alu_result[7];
                        c_q   <= (fff_q == 3'b000 || fff_q == 3'b001) ? alu_carry : 1'b0;
                    end
                    f_q         <= 3'd0;
                    result_en_q <= 1'b0;
                    done_q      <= 1'b1;
                    state_q     <= FINISH;
                end
                FINISH: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    f_q         <= 3'd0;
                    result_en_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign f         = f_q;
    assign result_en = result_en_q;
    assign load_a    = load_a_q;
    assign load_d    = load_d_q;
    assign result_q  = res_q;
    assign flag_z    = z_q;
    assign flag_s    = s_q;
    assign flag_c    = c_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_function_sequencer.sv
// Self-checking bench: directed scenarios plus random ALU instructions against a
// cycle-trace and architectural-state model of the sequencer.
module tb_alu_function_sequencer;

    localparam int S = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] instr;
    logic [7:0] alu_result;
    logic       alu_carry;
    logic [2:0] f;
    logic       result_en, load_a, load_d;
    logic [7:0] result_q;
    logic       flag_z, flag_s, flag_c;
    logic       busy, done, illegal;

    int checks = 0;
    int errors = 0;

    // architectural model state
    logic [7:0] m_res;
    logic       m_z, m_s, m_c;

    // observations gathered by run_op
    int done_cycle, n_la, n_ld, bad_cycles;

    alu_function_sequencer #(.SETTLE_CYCLES(S)) dut (
        .clk(clk), .reset(reset), .start(start), .instr(instr),
        .alu_result(alu_result), .alu_carry(alu_carry),
        .f(f), .result_en(result_en), .load_a(load_a), .load_d(load_d),
        .result_q(result_q), .flag_z(flag_z), .flag_s(flag_s), .flag_c(flag_c),
        .busy(busy), .done(done), .illegal(illegal)
    );

    always #5 clk = ~clk;

    // Issues one accepted instruction and records how each cycle compared with the
    // expected phase trace; optionally pulses a second start at cycle intrude_k.
    task automatic run_op(input logic [7:0] ins, input logic [7:0] res, input logic cy,
                          input int intrude_k, input logic [7:0] intrude_instr);
        logic [2:0] fff;
        logic       dest, ld, exp_en;
        logic [2:0] exp_f;
        fff = ins[2:0];
        dest = ins[3];
        done_cycle = 0; n_la = 0; n_ld = 0; bad_cycles = 0;
        @(posedge clk); #1;
        start = 1'b1; instr = ins; alu_result = res; alu_carry = cy;
        @(posedge clk); #1;
        start = 1'b0; instr = 8'h00;
        for (int k = 1; k <= 2*S+2; k++) begin
            @(negedge clk);
            ld     = (k == 2*S+1) && (fff != 3'b111);
            exp_f  = (k <= 2*S+1) ? fff : 3'b000;
            exp_en = (k > S) && (k <= 2*S+1);
            if (f !== exp_f || result_en !== exp_en || busy !== 1'b1 ||
                load_a !== (ld && !dest) || load_d !== (ld && dest) ||
                done !== (k == 2*S+2) || illegal !== 1'b0)
                bad_cycles++;
            if (load_a === 1'b1) n_la++;
            if (load_d === 1'b1) n_ld++;
            if (done === 1'b1 && done_cycle == 0) done_cycle = k;
            if (k == intrude_k) begin
                start = 1'b1; instr = intrude_instr; alu_result = ~res;
            end else begin
                start = 1'b0; instr = 8'h00; alu_result = res;
            end
        end
        start = 1'b0;
        if (fff != 3'b111) begin
            m_res = res;
            m_z = (res == 8'h00);
            m_s = res[7];
            m_c = (fff <= 3'd1) ? cy : 1'b0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; instr = 8'h00; alu_result = 8'h00; alu_carry = 1'b0;
        #12;
        m_res = 8'h00; m_z = 1'b0; m_s = 1'b0; m_c = 1'b0;
        checks++;
        if ({f, result_en, load_a, load_d, busy, done, illegal} !== 9'b0) begin
            errors++;
            $display("FAIL reset_ctrl got %b required 000000000", {f, result_en, load_a, load_d, busy, done, illegal});
        end
        checks++;
        if ({result_q, flag_z, flag_s, flag_c} !== 11'b0) begin
            errors++;
            $display("FAIL reset_data got %h/%b%b%b required 00/000", result_q, flag_z, flag_s, flag_c);
        end
        @(posedge clk); #1 reset = 1'b0;
    endtask

    task automatic test_add_to_a();
        run_op(8'h80, 8'h00, 1'b1, 0, 8'h00);
        checks++;
        if (done_cycle != 2*S+2) begin errors++; $display("FAIL add_latency got %0d required %0d", done_cycle, 2*S+2); end
        checks++;
        if (bad_cycles != 0 || n_la != 1 || n_ld != 0) begin
            errors++; $display("FAIL add_trace bad %0d load_a %0d load_d %0d required 0 1 0", bad_cycles, n_la, n_ld);
        end
        checks++;
        if ({result_q, flag_z, flag_s, flag_c} !== {8'h00, 1'b1, 1'b0, 1'b1}) begin
            errors++; $display("FAIL add_result got %h z%b s%b c%b required 00 z1 s0 c1", result_q, flag_z, flag_s, flag_c);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL add_idle busy %b required 0", busy); end
    endtask

    task automatic test_shl_to_d();
        run_op(8'h8E, 8'h96, 1'b1, 0, 8'h00);
        checks++;
        if (bad_cycles != 0 || n_la != 0 || n_ld != 1 || done_cycle != 2*S+2) begin
            errors++; $display("FAIL shl_trace bad %0d load_a %0d load_d %0d done %0d required 0 0 1 %0d", bad_cycles, n_la, n_ld, done_cycle, 2*S+2);
        end
        checks++;
        if ({result_q, flag_z, flag_s, flag_c} !== {8'h96, 1'b0, 1'b1, 1'b0}) begin
            errors++; $display("FAIL shl_result got %h z%b s%b c%b required 96 z0 s1 c0", result_q, flag_z, flag_s, flag_c);
        end
    endtask

    task automatic test_null();
        run_op(8'h81, 8'h55, 1'b0, 0, 8'h00);
        checks++;
        if (result_q !== 8'h55) begin errors++; $display("FAIL null_setup got %h required 55", result_q); end
        run_op(8'h8F, 8'hAA, 1'b1, 0, 8'h00);
        checks++;
        if (bad_cycles != 0 || n_la + n_ld != 0 || done_cycle != 2*S+2) begin
            errors++; $display("FAIL null_trace bad %0d strobes %0d done %0d required 0 0 %0d", bad_cycles, n_la + n_ld, done_cycle, 2*S+2);
        end
        checks++;
        if ({result_q, flag_z, flag_s, flag_c} !== {8'h55, 1'b0, 1'b0, 1'b0}) begin
            errors++; $display("FAIL null_hold got %h z%b s%b c%b required 55 z0 s0 c0", result_q, flag_z, flag_s, flag_c);
        end
    endtask

    task automatic test_illegal();
        @(posedge clk); #1;
        start = 1'b1; instr = 8'h40;
        @(posedge clk); #1;
        start = 1'b0; instr = 8'h00;
        @(negedge clk);
        checks++;
        if ({illegal, busy, load_a, load_d, result_en} !== 5'b10000) begin
            errors++; $display("FAIL illegal_pulse got %b required 10000", {illegal, busy, load_a, load_d, result_en});
        end
        @(negedge clk);
        checks++;
        if ({illegal, busy} !== 2'b00) begin errors++; $display("FAIL illegal_width got %b required 00", {illegal, busy}); end
        checks++;
        if ({result_q, flag_z, flag_s, flag_c} !== {m_res, m_z, m_s, m_c}) begin
            errors++; $display("FAIL illegal_flags got %h %b%b%b required %h %b%b%b", result_q, flag_z, flag_s, flag_c, m_res, m_z, m_s, m_c);
        end
    endtask

    task automatic test_start_during_drive();
        run_op(8'h83, 8'h3C, 1'b1, S+2, 8'h8E);
        checks++;
        if (bad_cycles != 0 || n_la != 1 || n_ld != 0 || done_cycle != 2*S+2) begin
            errors++; $display("FAIL busy_start_trace bad %0d load_a %0d load_d %0d done %0d", bad_cycles, n_la, n_ld, done_cycle);
        end
        checks++;
        if ({result_q, flag_z, flag_s, flag_c} !== {8'h3C, 1'b0, 1'b0, 1'b0}) begin
            errors++; $display("FAIL busy_start_result got %h z%b s%b c%b required 3c z0 s0 c0", result_q, flag_z, flag_s, flag_c);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL busy_start_idle busy %b required 0", busy); end
    endtask

    task automatic test_reset_mid_op();
        @(posedge clk); #1;
        start = 1'b1; instr = 8'h80; alu_result = 8'h77; alu_carry = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; instr = 8'h00;
        repeat (S+2) @(negedge clk);
        checks++;
        if (result_en !== 1'b1) begin errors++; $display("FAIL mid_drive result_en %b required 1", result_en); end
        #2 reset = 1'b1;
        #1;
        m_res = 8'h00; m_z = 1'b0; m_s = 1'b0; m_c = 1'b0;
        checks++;
        if ({result_en, busy, f, done, load_a, load_d} !== 8'b0) begin
            errors++; $display("FAIL mid_reset_async got %b required 00000000", {result_en, busy, f, done, load_a, load_d});
        end
        repeat (S+2) begin
            @(negedge clk);
            checks++;
            if ({load_a, load_d, result_q} !== 10'b0) begin
                errors++; $display("FAIL mid_reset_hold got %b %b %h required 0 0 00", load_a, load_d, result_q);
            end
        end
        @(posedge clk); #1 reset = 1'b0;
        run_op(8'h80, 8'h12, 1'b0, 0, 8'h00);
        checks++;
        if (bad_cycles != 0 || n_la != 1 || done_cycle != 2*S+2 ||
            {result_q, flag_z, flag_s, flag_c} !== {8'h12, 1'b0, 1'b0, 1'b0}) begin
            errors++; $display("FAIL post_reset_op bad %0d load_a %0d done %0d result %h", bad_cycles, n_la, done_cycle, result_q);
        end
    endtask

    task automatic test_random();
        logic [7:0] ins, res;
        logic       cy;
        for (int i = 0; i < 30; i++) begin
            ins = {4'b1000, 4'($urandom_range(0, 15))};
            res = 8'($urandom);
            if (i % 7 == 0) res = 8'h00;
            cy  = 1'($urandom);
            run_op(ins, res, cy, 0, 8'h00);
            checks++;
            if (bad_cycles != 0 || done_cycle != 2*S+2 ||
                n_la != ((ins[2:0] != 3'b111 && !ins[3]) ? 1 : 0) ||
                n_ld != ((ins[2:0] != 3'b111 && ins[3]) ? 1 : 0)) begin
                errors++; $display("FAIL rand_trace instr %h bad %0d load_a %0d load_d %0d done %0d", ins, bad_cycles, n_la, n_ld, done_cycle);
            end
            checks++;
            if ({result_q, flag_z, flag_s, flag_c} !== {m_res, m_z, m_s, m_c}) begin
                errors++; $display("FAIL rand_result instr %h got %h %b%b%b required %h %b%b%b", ins, result_q, flag_z, flag_s, flag_c, m_res, m_z, m_s, m_c);
            end
        end
    endtask

    initial begin
        test_reset();
        test_add_to_a();
        test_shl_to_d();
        test_null();
        test_illegal();
        test_start_during_drive();
        test_reset_mid_op();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
